// File: rtl/useq_pkg.sv
// Shared definitions for the micro-sequenced fetch controller.
// Used by useq_fetch_ctrl and by the decoders, regfile and ALU, which compare
// cpu_state against useq_state_t.
//   useq_state_t  3-bit FSM state encoding (exported on cpu_state)
//   *_DEF         default width constants
//   bcnt_width()  bit-counter width covering the longest serial phase
package useq_pkg;

  localparam int PC_W_DEF     = 8;
  localparam int INST_W_DEF   = 16;
  localparam int MPC_W_DEF    = 5;
  localparam int MADDR_W_DEF  = 9;
  localparam int MINST_W_DEF  = 24;
  localparam int MAX_UOPS_DEF = 32;

  typedef enum logic [2:0] {
    ST_SEND_PC      = 3'd0,
    ST_FETCH        = 3'd1,
    ST_DECODE       = 3'd2,
    ST_SEND_MPC     = 3'd3,
    ST_FETCH_MINST  = 3'd4,
    ST_DECODE_MINST = 3'd5,
    ST_EXEC1        = 3'd6,
    ST_EXEC2        = 3'd7
  } useq_state_t;

  // Width of a counter that must reach (longest serial length - 1).
  function automatic int bcnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/useq_ser_shift.sv
// W-bit shift register usable as serialiser or deserialiser.
//   clk, rst_n  clock, async active-low reset (clears register)
//   load        parallel load of load_val (wins over shift_en)
//   shift_en    shift left by one, ser_in enters at bit 0
//   par_out     register contents
//   ser_out     register MSB (MSB-first serial output)
module useq_ser_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         ser_in,
  output logic [W-1:0] par_out,
  output logic         ser_out
);

  logic [W-1:0] sreg_q, sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load)          sreg_d = load_val;
    else if (shift_en) sreg_d = W'({sreg_q, ser_in});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sreg_q <= '0;
    else        sreg_q <= sreg_d;
  end

  assign par_out = sreg_q;
  assign ser_out = sreg_q[W-1];

endmodule

// File: rtl/useq_fetch_ctrl.sv
// Serial fetch / micro-sequencing controller. Streams the PC out, shifts the
// instruction in, then for each uop streams the micro-store address out and
// shifts the micro-instruction in before a two-cycle execute (EXEC1/EXEC2).
// Owns PC, micro-PC, IR and micro-IR.
// Optional build macro USEQ_SER_READY_EN: serial phases advance only on cycles
// with ser_ready=1; without it ser_ready is ignored and every cycle is a beat.
// Ports:
//   sys_clk, sys_reset_n                  clock, async active-low reset
//   instr_in, m_instr_in                  serial instruction / uop bits in
//   ser_ready                             serial link ready (macro build only)
//   is_nop, is_micro_nop                  decoder NOP flags (DECODE / DECODE_MINST)
//   uop_last, ubranch_take/_target        sequence control, sampled in EXEC2
//   pc_branch_take/_target                PC redirect at end of instruction
//   m_inst_base                           micro-store base of current instruction
//   inst_addr_stream, m_inst_addr_stream  serial PC / micro-address out
//   cpu_state, pc, m_pc, instr_reg, m_instr_reg  architectural state
//   exec1_stb, exec2_stb, inst_done       phase strobes / retire pulse
module useq_fetch_ctrl
  import useq_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int INST_W   = INST_W_DEF,
  parameter int MPC_W    = MPC_W_DEF,
  parameter int MADDR_W  = MADDR_W_DEF,
  parameter int MINST_W  = MINST_W_DEF,
  parameter int MAX_UOPS = MAX_UOPS_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_reset_n,
  input  logic               instr_in,
  input  logic               m_instr_in,
  input  logic               ser_ready,
  input  logic               is_nop,
  input  logic               is_micro_nop,
  input  logic               uop_last,
  input  logic               ubranch_take,
  input  logic [MPC_W-1:0]   ubranch_target,
  input  logic               pc_branch_take,
  input  logic [PC_W-1:0]    pc_branch_target,
  input  logic [MADDR_W-1:0] m_inst_base,
  output logic               inst_addr_stream,
  output logic               m_inst_addr_stream,
  output logic [2:0]         cpu_state,
  output logic [PC_W-1:0]    pc,
  output logic [MPC_W-1:0]   m_pc,
  output logic [INST_W-1:0]  instr_reg,
  output logic [MINST_W-1:0] m_instr_reg,
  output logic               exec1_stb,
  output logic               exec2_stb,
  output logic               inst_done
);

  localparam int BCNT_W = bcnt_width(PC_W, INST_W, MADDR_W, MINST_W);

  useq_state_t        state_q, state_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [MPC_W-1:0]   m_pc_q, m_pc_d;
  logic               done_q, done_d;
  logic               beat, retire, uop_cap;

`ifdef USEQ_SER_READY_EN
  assign beat = ser_ready;
`else
  logic unused_ser_ready;
  assign unused_ser_ready = ser_ready;
  assign beat = 1'b1;
`endif

  // ">=" rather than "==" so a micro-branch beyond the cap still terminates
  // on the following EXEC2.
  assign uop_cap = (m_pc_q >= MPC_W'(MAX_UOPS - 1));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    pc_d    = pc_q;
    m_pc_d  = m_pc_q;
    done_d  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_SEND_PC: if (beat) begin
        if (bcnt_q == BCNT_W'(PC_W - 1)) state_d = ST_FETCH;
        else                             bcnt_d  = bcnt_q + BCNT_W'(1);
      end
      ST_FETCH: if (beat) begin
        if (bcnt_q == BCNT_W'(INST_W - 1)) state_d = ST_DECODE;
        else                               bcnt_d  = bcnt_q + BCNT_W'(1);
      end
      ST_DECODE: begin
        m_pc_d = '0;
        if (is_nop) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_SEND_PC;
        end else begin
          state_d = ST_SEND_MPC;
        end
      end
      ST_SEND_MPC: if (beat) begin
        if (bcnt_q == BCNT_W'(MADDR_W - 1)) state_d = ST_FETCH_MINST;
        else                                bcnt_d  = bcnt_q + BCNT_W'(1);
      end
      ST_FETCH_MINST: if (beat) begin
        if (bcnt_q == BCNT_W'(MINST_W - 1)) state_d = ST_DECODE_MINST;
        else                                bcnt_d  = bcnt_q + BCNT_W'(1);
      end
      ST_DECODE_MINST: begin
        if (is_micro_nop) begin
          if (uop_cap) retire = 1'b1;
          else begin
            m_pc_d  = m_pc_q + MPC_W'(1);
            state_d = ST_SEND_MPC;
          end
        end else begin
          state_d = ST_EXEC1;
        end
      end
      ST_EXEC1: state_d = ST_EXEC2;
      ST_EXEC2: begin
        // End of sequence takes priority over a micro-branch.
        if (uop_last || uop_cap) retire = 1'b1;
        else if (ubranch_take) begin
          m_pc_d  = ubranch_target;
          state_d = ST_SEND_MPC;
        end else begin
          m_pc_d  = m_pc_q + MPC_W'(1);
          state_d = ST_SEND_MPC;
        end
      end
      default: state_d = ST_SEND_PC;
    endcase
    if (retire) begin
      pc_d    = pc_branch_take ? pc_branch_target : pc_q + PC_W'(1);
      m_pc_d  = '0;
      done_d  = 1'b1;
      state_d = ST_SEND_PC;
    end
    if (state_d != state_q) bcnt_d = '0;
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q <= ST_SEND_PC;
      bcnt_q  <= '0;
      pc_q    <= '0;
      m_pc_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      pc_q    <= pc_d;
      m_pc_q  <= m_pc_d;
      done_q  <= done_d;
    end
  end

  // Serialisers are loaded on the edge that enters their send state, so the
  // MSB is on the wire in the first cycle of that state.
  logic               pc_load, maddr_load, fetch_sh, mfetch_sh;
  logic               pc_bit, maddr_bit;
  logic [MADDR_W-1:0] maddr_next;

  assign pc_load    = (state_d == ST_SEND_PC)  && (state_q != ST_SEND_PC);
  assign maddr_load = (state_d == ST_SEND_MPC) && (state_q != ST_SEND_MPC);
  assign maddr_next = m_inst_base + MADDR_W'(m_pc_d);
  assign fetch_sh   = (state_q == ST_FETCH)       && beat;
  assign mfetch_sh  = (state_q == ST_FETCH_MINST) && beat;

  logic [PC_W-1:0]    unused_pc_par;
  logic [MADDR_W-1:0] unused_maddr_par;
  logic               unused_ir_ser, unused_mir_ser;

  useq_ser_shift #(.W(PC_W)) u_pc_ser (
    .clk(sys_clk), .rst_n(sys_reset_n), .load(pc_load), .load_val(pc_d),
    .shift_en((state_q == ST_SEND_PC) && beat), .ser_in(1'b0),
    .par_out(unused_pc_par), .ser_out(pc_bit)
  );

  useq_ser_shift #(.W(MADDR_W)) u_maddr_ser (
    .clk(sys_clk), .rst_n(sys_reset_n), .load(maddr_load), .load_val(maddr_next),
    .shift_en((state_q == ST_SEND_MPC) && beat), .ser_in(1'b0),
    .par_out(unused_maddr_par), .ser_out(maddr_bit)
  );

  useq_ser_shift #(.W(INST_W)) u_ir_des (
    .clk(sys_clk), .rst_n(sys_reset_n), .load(1'b0), .load_val('0),
    .shift_en(fetch_sh), .ser_in(instr_in),
    .par_out(instr_reg), .ser_out(unused_ir_ser)
  );

  useq_ser_shift #(.W(MINST_W)) u_mir_des (
    .clk(sys_clk), .rst_n(sys_reset_n), .load(1'b0), .load_val('0),
    .shift_en(mfetch_sh), .ser_in(m_instr_in),
    .par_out(m_instr_reg), .ser_out(unused_mir_ser)
  );

  assign inst_addr_stream   = (state_q == ST_SEND_PC)  && pc_bit;
  assign m_inst_addr_stream = (state_q == ST_SEND_MPC) && maddr_bit;
  assign cpu_state          = state_q;
  assign pc                 = pc_q;
  assign m_pc               = m_pc_q;
  assign exec1_stb          = (state_q == ST_EXEC1);
  assign exec2_stb          = (state_q == ST_EXEC2);
  // NOP skip retires combinationally in DECODE; sequenced retire is registered
  // and shows in the first SEND_PC cycle.
  assign inst_done          = done_q || ((state_q == ST_DECODE) && is_nop);

endmodule
